// File: rtl/axis_split_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : axis_split_rr_scheduler
//  Purpose  : Round-robin scheduler that shares one AXI-Stream master port
//             between NUM requester streams. Each grant carries at most
//             max_len beats (0 = unlimited). When the limit is reached, the
//             block forces tlast and rotates the grant, so long packets are
//             interleaved as fragments. m_tuser marks the beat that carried
//             the requester's real tlast, which lets downstream logic
//             reassemble the fragments.
//  Ports    : clock, rst      - single clock, synchronous active-high reset
//             max_len         - fragment length limit, sampled at grant time
//             s_t*            - NUM packed requester streams (slave side)
//             m_t*            - shared output stream; m_tid = granted index
//             busy            - high while a grant is held
//  Revision : 1.0 - initial release
// ============================================================================
module axis_split_rr_scheduler #(
    parameter int NUM   = 4,
    parameter int DSIZE = 32,
    parameter int IW    = $clog2(NUM)
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [31:0]            max_len,
    input  logic [NUM-1:0]         s_tvalid,
    input  logic [NUM*DSIZE-1:0]   s_tdata,
    input  logic [NUM*DSIZE/8-1:0] s_tkeep,
    input  logic [NUM-1:0]         s_tlast,
    output logic [NUM-1:0]         s_tready,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [DSIZE-1:0]       m_tdata,
    output logic [DSIZE/8-1:0]     m_tkeep,
    output logic                   m_tlast,
    output logic                   m_tuser,
    output logic [IW-1:0]          m_tid,
    output logic                   busy
);

    localparam int c_KW = DSIZE / 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_gnt;
    logic [31:0]      r_cnt;
    logic [31:0]      r_len_q;
    logic             r_busy;

    logic [DSIZE-1:0] w_data_arr [NUM];
    logic [c_KW-1:0]  w_keep_arr [NUM];
    logic [IW-1:0]    w_pick;
    logic [IW:0]      w_sum;
    logic [IW-1:0]    w_gnt_next;
    logic             w_lock;
    logic             w_len_hit;
    logic             w_frag_end;
    logic             w_hs;

    // Unpack the flat requester buses so the output mux is a plain array index.
    for (genvar gi = 0; gi < NUM; gi++) begin : g_unpack
        assign w_data_arr[gi] = s_tdata[gi*DSIZE +: DSIZE];
        assign w_keep_arr[gi] = s_tkeep[gi*c_KW +: c_KW];
    end

    // Round-robin pick: scan offsets from the far end toward ptr so that the
    // valid requester closest to ptr (in wrap-around order) is the last write.
    always_comb begin
        w_pick = '0;
        w_sum  = '0;
        for (int k = NUM - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NUM)) begin
                w_sum = w_sum - (IW+1)'(NUM);
            end
            if (s_tvalid[w_sum[IW-1:0]]) begin
                w_pick = w_sum[IW-1:0];
            end
        end
    end

    assign w_gnt_next = (r_gnt == IW'(NUM - 1)) ? '0 : r_gnt + IW'(1);

    assign w_lock     = (r_state == ST_LOCK);
    // len_q == 0 means "no length limit"; guard keeps len_q-1 from underflowing
    // into a false match.
    assign w_len_hit  = (r_len_q != 32'd0) && (r_cnt == r_len_q - 32'd1);
    assign w_frag_end = s_tlast[r_gnt] | w_len_hit;

    assign m_tvalid   = w_lock & s_tvalid[r_gnt];
    assign m_tdata    = w_data_arr[r_gnt];
    assign m_tkeep    = w_keep_arr[r_gnt];
    assign m_tlast    = w_lock & w_frag_end;
    assign m_tuser    = w_lock & s_tlast[r_gnt];
    assign m_tid      = r_gnt;
    assign busy       = r_busy;
    assign w_hs       = m_tvalid & m_tready;

    // Only the granted requester sees the downstream ready.
    always_comb begin
        s_tready = '0;
        if (w_lock) begin
            s_tready[r_gnt] = m_tready;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_len_q <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|s_tvalid) begin
                        r_gnt   <= w_pick;
                        r_len_q <= max_len;
                        r_cnt   <= '0;
                        r_state <= ST_LOCK;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (w_hs) begin
                        if (w_frag_end) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_ptr   <= w_gnt_next;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt   <= r_cnt + 32'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_split_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_split_rr_scheduler
//  Purpose  : Self-checking bench for axis_split_rr_scheduler. Requester
//             sources replay queued packets. A transaction-level reference
//             (grant, pointer, beats-in-grant) predicts every cycle's outputs.
//             Fragment tables describe the directed cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_split_rr_scheduler;

    localparam int NUM   = 4;
    localparam int DSIZE = 32;
    localparam int KW    = DSIZE / 8;
    localparam int IW    = $clog2(NUM);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [31:0]          max_len;
    logic [NUM-1:0]       s_tvalid;
    logic [NUM*DSIZE-1:0] s_tdata;
    logic [NUM*KW-1:0]    s_tkeep;
    logic [NUM-1:0]       s_tlast;
    logic [NUM-1:0]       s_tready;
    logic                 m_tvalid;
    logic                 m_tready;
    logic [DSIZE-1:0]     m_tdata;
    logic [KW-1:0]        m_tkeep;
    logic                 m_tlast;
    logic                 m_tuser;
    logic [IW-1:0]        m_tid;
    logic                 busy;

    always #5 clk = ~clk;

    axis_split_rr_scheduler #(.NUM(NUM), .DSIZE(DSIZE)) dut (
        .clock   (clk),
        .rst     (rst),
        .max_len (max_len),
        .s_tvalid(s_tvalid),
        .s_tdata (s_tdata),
        .s_tkeep (s_tkeep),
        .s_tlast (s_tlast),
        .s_tready(s_tready),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tdata (m_tdata),
        .m_tkeep (m_tkeep),
        .m_tlast (m_tlast),
        .m_tuser (m_tuser),
        .m_tid   (m_tid),
        .busy    (busy)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        int   tid;
        logic last;
        logic user;
    } obs_t;

    typedef struct {
        int unsigned ml;
        int          lens  [NUM];
        int          nfrag;
        int          ftid  [6];
        int          flen  [6];
        bit          fuser [6];
    } vec_t;

    beat_t       src_q [NUM][$];
    beat_t       exp_q [NUM][$];
    bit          src_pres [NUM];
    obs_t        obs_q [$];

    int          vrate   = 100;
    int          rrate   = 100;
    bit          ml_rand = 1'b0;
    bit          rst_req = 1'b0;
    int          pkt_tag = 0;

    // Reference: who holds the grant, where the rotation restarts, and how
    // many beats the current grant has moved.
    bit          mdl_lock = 1'b0;
    int          mdl_gnt  = 0;
    int          mdl_ptr  = 0;
    int          mdl_cnt  = 0;
    logic [31:0] mdl_len  = '0;

    int          vectors     = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_pkt(input int r, input int n);
        beat_t b;
        pkt_tag++;
        for (int i = 0; i < n; i++) begin
            b.data = {pkt_tag[7:0], 8'(r), 16'(i)};
            b.keep = 4'($urandom_range(1, 15));
            b.last = (i == n - 1);
            src_q[r].push_back(b);
            exp_q[r].push_back(b);
        end
    endtask

    task automatic drive();
        logic [NUM-1:0]       tv;
        logic [NUM-1:0]       tl;
        logic [NUM*DSIZE-1:0] td;
        logic [NUM*KW-1:0]    tk;
        for (int i = 0; i < NUM; i++) begin
            if (!src_pres[i] && src_q[i].size() > 0 && int'($urandom_range(0, 99)) < vrate)
                src_pres[i] = 1'b1;
            tv[i] = src_pres[i];
            if (src_pres[i]) begin
                td[i*DSIZE +: DSIZE] = src_q[i][0].data;
                tk[i*KW +: KW]       = src_q[i][0].keep;
                tl[i]                = src_q[i][0].last;
            end else begin
                td[i*DSIZE +: DSIZE] = $urandom;
                tk[i*KW +: KW]       = 4'($urandom);
                tl[i]                = 1'($urandom);
            end
        end
        s_tvalid = tv;
        s_tdata  = td;
        s_tkeep  = tk;
        s_tlast  = tl;
        rst      = rst_req;
        m_tready = rst_req ? 1'b0 : (int'($urandom_range(0, 99)) < rrate);
        if (ml_rand) max_len = $urandom_range(0, 4);
    endtask

    task automatic check_cycle();
        beat_t e;
        bit    lenhit;
        bit    fend;
        if (!mdl_lock) begin
            chk("idle_m_tvalid", m_tvalid, 0);
            chk("idle_s_tready", s_tready, 0);
            chk("idle_busy", busy, 0);
            if (s_tvalid != '0) begin
                for (int k = 0; k < NUM; k++) begin
                    if (s_tvalid[(mdl_ptr + k) % NUM]) begin
                        mdl_gnt = (mdl_ptr + k) % NUM;
                        break;
                    end
                end
                mdl_lock = 1'b1;
                mdl_len  = max_len;
                mdl_cnt  = 0;
            end
        end else begin
            chk("lock_busy", busy, 1);
            chk("lock_m_tid", m_tid, mdl_gnt);
            chk("lock_m_tvalid", m_tvalid, s_tvalid[mdl_gnt]);
            chk("lock_s_tready", s_tready, m_tready ? (NUM'(1) << mdl_gnt) : NUM'(0));
            if (s_tvalid[mdl_gnt]) begin
                if (exp_q[mdl_gnt].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_beat: requester %0d presents a beat, none expected", mdl_gnt);
                end else begin
                    e      = exp_q[mdl_gnt][0];
                    lenhit = (mdl_len != 0) && (mdl_cnt + 1 == int'(mdl_len));
                    fend   = e.last || lenhit;
                    chk("m_tdata", m_tdata, e.data);
                    chk("m_tkeep", m_tkeep, e.keep);
                    chk("m_tuser", m_tuser, e.last);
                    chk("m_tlast", m_tlast, fend);
                    if (m_tready) begin
                        void'(exp_q[mdl_gnt].pop_front());
                        mdl_cnt++;
                        if (fend) begin
                            mdl_lock = 1'b0;
                            mdl_ptr  = (mdl_gnt + 1) % NUM;
                        end
                    end
                end
            end
        end
        if (m_tvalid && m_tready) obs_q.push_back('{int'(m_tid), m_tlast, m_tuser});
        for (int i = 0; i < NUM; i++) begin
            if (s_tvalid[i] && s_tready[i]) begin
                void'(src_q[i].pop_front());
                src_pres[i] = 1'b0;
            end
        end
        if (rst_req) begin
            mdl_lock = 1'b0;
            mdl_ptr  = 0;
            mdl_gnt  = 0;
            mdl_cnt  = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        #1;
        check_cycle();
    endtask

    function automatic bit drained();
        for (int i = 0; i < NUM; i++)
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        return !mdl_lock;
    endfunction

    task automatic apply_reset();
        rst_req = 1'b1;
        step();
        step();
        chk("rst_m_tid", m_tid, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        rst_req = 1'b0;
    endtask

    task automatic run_until_drained(input int limit, input string name);
        int n = 0;
        while (!drained() && n < limit) begin
            step();
            n++;
        end
        vectors++;
        if (!drained()) begin
            miscompares++;
            $display("FAIL %s_timeout: still pending after %0d cycles, expected drained", name, limit);
            for (int i = 0; i < NUM; i++) begin
                src_q[i].delete();
                exp_q[i].delete();
                src_pres[i] = 1'b0;
            end
            apply_reset();
        end
    endtask

    initial begin
        vec_t tbl [4];
        int   fi;
        int   cur;
        int   n;

        rst      = 1'b1;
        max_len  = '0;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        m_tready = 1'b0;

        tbl[0] = '{4, '{10, 0, 0, 0}, 3, '{0, 0, 0, 0, 0, 0}, '{4, 4, 2, 0, 0, 0}, '{0, 0, 1, 0, 0, 0}};
        tbl[1] = '{4, '{8, 0, 8, 0},  4, '{0, 2, 0, 2, 0, 0}, '{4, 4, 4, 4, 0, 0}, '{0, 0, 1, 1, 0, 0}};
        tbl[2] = '{0, '{0, 6, 0, 6},  2, '{1, 3, 0, 0, 0, 0}, '{6, 6, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0}};
        tbl[3] = '{1, '{2, 2, 2, 0},  6, '{0, 1, 2, 0, 1, 2}, '{1, 1, 1, 1, 1, 1}, '{0, 0, 0, 1, 1, 1}};

        // Directed fragment tables, full throughput.
        for (int v = 0; v < 4; v++) begin
            apply_reset();
            max_len = tbl[v].ml;
            vrate   = 100;
            rrate   = 100;
            obs_q.delete();
            for (int r = 0; r < NUM; r++)
                if (tbl[v].lens[r] > 0) add_pkt(r, tbl[v].lens[r]);
            run_until_drained(200, "table");
            fi  = 0;
            cur = 0;
            foreach (obs_q[j]) begin
                cur++;
                if (obs_q[j].last) begin
                    if (fi < tbl[v].nfrag) begin
                        chk("frag_tid", obs_q[j].tid, tbl[v].ftid[fi]);
                        chk("frag_len", cur, tbl[v].flen[fi]);
                        chk("frag_user", obs_q[j].user, tbl[v].fuser[fi]);
                    end
                    fi++;
                    cur = 0;
                end
            end
            chk("frag_count", fi, tbl[v].nfrag);
        end

        // Random backpressure on both sides, max_len fixed at 3.
        apply_reset();
        max_len = 3;
        vrate   = 60;
        rrate   = 60;
        for (int r = 0; r < NUM; r++)
            for (int p = 0; p < 5; p++) add_pkt(r, $urandom_range(1, 9));
        run_until_drained(4000, "rand_ml3");

        // max_len changes every cycle; only the value seen at grant applies.
        ml_rand = 1'b1;
        vrate   = 50;
        rrate   = 70;
        for (int r = 0; r < NUM; r++)
            for (int p = 0; p < 4; p++) add_pkt(r, $urandom_range(1, 8));
        run_until_drained(4000, "rand_mlvar");
        ml_rand = 1'b0;

        // Reset in the middle of a fragment: pointer must return to 0.
        apply_reset();
        max_len = 5;
        vrate   = 100;
        rrate   = 100;
        add_pkt(1, 1);
        run_until_drained(50, "rst_pre");
        obs_q.delete();
        add_pkt(2, 10);
        n = 0;
        while (obs_q.size() < 2 && n < 20) begin
            step();
            n++;
        end
        chk("rst_beats_before", obs_q.size(), 2);
        add_pkt(0, 3);
        add_pkt(3, 3);
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        chk("rst_mid_m_tvalid", m_tvalid, 0);
        chk("rst_mid_s_tready", s_tready, 0);
        chk("rst_mid_m_tid", m_tid, 0);
        step();
        chk("rst_next_gnt", m_tid, 0);
        run_until_drained(300, "rst_post");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
